// File: rtl/if_id_fifo.sv
// Purpose : DEPTH-entry {pc, inst} instruction buffer between fetch (IF) and decode (ID).
// Latency : an entry pushed at edge N is visible on id_* right after that edge; up to 1 instr/cycle.
// Backpres: if_ready drops when full, and IF holds its request. id_ready is ignored while empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           discard every buffered entry; an instruction offered in the same cycle is dropped
//   if_valid/if_ready, if_pc/if_inst   fetch-side handshake and payload
//   if_afull        occupancy >= AFULL_LVL, for fetch throttling
//   id_valid/id_ready, id_pc/id_inst   decode-side handshake and head payload (bubble when empty)
//   count           current occupancy, 0..DEPTH
module if_id_fifo #(
  parameter int unsigned      ADDR_W    = 32,
  parameter int unsigned      INST_W    = 32,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      AFULL_LVL = DEPTH - 1,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  output logic                       if_afull,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   cnt_q;
  entry_t             head_ent;
  logic               push;
  logic               pop;
  logic               clear;

  // All outputs come from registered state only; if_valid and id_ready only
  // steer the next state.
  assign if_ready = (cnt_q != DEPTH_C);
  assign id_valid = (cnt_q != '0);
  assign if_afull = (32'(cnt_q) >= AFULL_LVL);
  assign count    = cnt_q;
  assign head_ent = mem[head];
  assign id_pc    = id_valid ? head_ent.pc   : '0;
  assign id_inst  = id_valid ? head_ent.inst : NOP_INST;

  // A pop in the same cycle never opens a slot for a push when full:
  // if_ready depends only on the registered count.
  assign push  = if_valid & if_ready;
  assign pop   = id_valid & id_ready;
  assign clear = rst | flush;

  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not cleared on reset or flush. Entries past the pointers are never observed.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= '{pc: if_pc, inst: if_inst};
  end

  always_ff @(posedge clk) begin
    assert ((DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))
      else $error("if_id_fifo: DEPTH must be a power of two >= 2");
    if (!rst) begin
      assert (cnt_q <= DEPTH_C)
        else $error("if_id_fifo: occupancy exceeds DEPTH");
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
module tb_if_id_fifo;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        if_afull;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  if_id_fifo #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .AFULL_LVL(DEPTH-1), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .if_afull(if_afull),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  bit chk_en = 1'b0;
  bit seen_200 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an ordered list of accepted {pc, inst} pairs.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t q[$];

  always @(posedge clk) begin
    bit do_push, do_pop;
    if (rst || flush) begin
      q.delete();
    end else begin
      do_push = if_valid && (q.size() < DEPTH);
      do_pop  = id_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: if_pc, inst: if_inst});
    end
  end

  // Compare DUT against the model on every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("id_valid", 32'(id_valid), 32'(q.size() != 0));
      chk("id_pc",    id_pc,   (q.size() != 0) ? q[0].pc   : 32'h0);
      chk("id_inst",  id_inst, (q.size() != 0) ? q[0].inst : NOP);
      chk("count",    32'(count), 32'(q.size()));
      chk("if_ready", 32'(if_ready), 32'(q.size() != DEPTH));
      chk("if_afull", 32'(if_afull), 32'(q.size() >= DEPTH-1));
      if (id_valid && id_pc == 32'h200) seen_200 = 1'b1;
    end
  end

  // Drive one cycle of inputs, then sample #1 after the edge that consumes them.
  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
    @(negedge clk);
    rst = r; flush = f; if_valid = v; if_pc = pc; if_inst = inst; id_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h5A00_0013;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a valid offer present.
    cyc(1, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    chk_en = 1'b1;
    cyc(1, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst",  id_inst, NOP);
    chk("rst_id_pc",    id_pc, 32'h0);
    chk("rst_count",    32'(count), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);

    // Latency and order.
    cyc(0, 0, 1, 32'h100, 32'h00A00093, 0);
    chk("lat_pc",   id_pc, 32'h100);
    chk("lat_inst", id_inst, 32'h00A00093);
    cyc(0, 0, 1, 32'h104, 32'h00100113, 0);
    cyc(0, 0, 1, 32'h108, 32'h002081B3, 0);
    chk("ord_count", 32'(count), 32'd3);
    chk("ord_afull", 32'(if_afull), 32'd1);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("ord_pc1", id_pc, 32'h104);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("ord_pc2", id_pc, 32'h108);
    chk("ord_inst2", id_inst, 32'h002081B3);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("ord_bubble_v",    32'(id_valid), 32'd0);
    chk("ord_bubble_inst", id_inst, NOP);

    // Full: four accepted, the fifth held by IF.
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h10 + 32'(4*i), mk_inst(32'h10 + 32'(4*i)), 0);
    chk("full_ready", 32'(if_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    cyc(0, 0, 1, 32'h20, mk_inst(32'h20), 0);
    chk("full_hold_count", 32'(count), 32'd4);
    cyc(0, 0, 1, 32'h20, mk_inst(32'h20), 1);
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_pc",    id_pc, 32'h14);
    cyc(0, 0, 1, 32'h20, mk_inst(32'h20), 0);
    chk("full_accept_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("full_drain_count", 32'(count), 32'd0);

    // Steady push+pop at count 2 with pointer wrap.
    cyc(0, 0, 1, 32'h1000, mk_inst(32'h1000), 0);
    cyc(0, 0, 1, 32'h1004, mk_inst(32'h1004), 0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 1, 32'h1008 + 32'(4*k), mk_inst(32'h1008 + 32'(4*k)), 1);
      chk("steady_count", 32'(count), 32'd2);
      chk("steady_pc",    id_pc, 32'h1000 + 32'(4*(k+1)));
    end
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("steady_empty", 32'(id_valid), 32'd0);

    // Flush drops buffered entries and the same-cycle offer.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h40 + 32'(4*i), mk_inst(32'h40 + 32'(4*i)), 0);
    chk("pre_flush_count", 32'(count), 32'd3);
    cyc(0, 1, 1, 32'h200, mk_inst(32'h200), 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    cyc(0, 0, 1, 32'h300, mk_inst(32'h300), 0);
    chk("post_flush_pc",    id_pc, 32'h300);
    chk("post_flush_count", 32'(count), 32'd1);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 32'h0, 0);
    chk("flush_200_never", 32'(seen_200), 32'd0);

    // Reset while full.
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h80 + 32'(4*i), mk_inst(32'h80 + 32'(4*i)), 0);
    chk("pre_rst_count", 32'(count), 32'd4);
    cyc(1, 0, 1, 32'h500, mk_inst(32'h500), 1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ready", 32'(if_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 32'h0, 32'h0, 1);
      chk("post_rst_valid", 32'(id_valid), 32'd0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/if_id_fifo.md
Name: if_id_fifo

Overview:
- Parametrised instruction buffer between IF and ID: the next generation of the single-entry IF/ID register.
- Replaces the stall-vector/bubble scheme with a valid/ready handshake and a DEPTH-entry FIFO of {pc, inst} pairs.
- Decouples fetch from decode stalls. Supports a branch/exception flush.
- Presents a bubble (pc=0, inst=NOP_INST) to ID when empty.

Parameters:
ADDR_W, 32, width of pc
INST_W, 32, width of instruction word
DEPTH, 4, number of entries; power of two, >=2
AFULL_LVL, DEPTH-1, occupancy at or above which if_afull asserts
NOP_INST, 32'h00000000, instruction presented to ID when id_valid=0

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  discard all buffered entries (branch redirect/exception)
if_valid  input  1  IF presents a valid instruction this cycle
if_pc  input  ADDR_W  pc of the offered instruction
if_inst  input  INST_W  offered instruction
if_ready  output  1  buffer can accept; equals !full
if_afull  output  1  count >= AFULL_LVL, for fetch throttling
id_valid  output  1  head entry valid; equals count!=0
id_ready  input  1  ID consumes the head entry this cycle
id_pc  output  ADDR_W  head pc, or 0 when empty
id_inst  output  INST_W  head instruction, or NOP_INST when empty
count  output  $clog2(DEPTH+1)  current occupancy 0..DEPTH

Behaviour:
- Storage: DEPTH-entry register array, head and tail pointers of $clog2(DEPTH) bits, and a count register.
- Pointers wrap naturally modulo DEPTH.
- push = if_valid & if_ready.
- pop = id_valid & id_ready.
- if_ready = (count != DEPTH). No write-through when full: a same-cycle pop does not open a slot for the push.
- Outputs id_valid/id_pc/id_inst/if_ready/if_afull/count are decoded from registered state only. No combinational path from if_* or id_ready to any output.
- Latency: an entry pushed in cycle N is visible on id_* in cycle N+1 (same timing as the old single register). Throughput is 1 instr/cycle when not full.
- Ordering: strict FIFO.
- push only: write mem[tail], tail+1, count+1.
- pop only: head+1, count-1.
- push and pop together: both pointers advance, count unchanged. Legal for 0<count<DEPTH.
- Empty: id_valid=0, id_pc=0, id_inst=NOP_INST. id_ready is ignored.
- Full: if_ready=0. if_valid is ignored and IF must hold its request.
- Priority, highest first:
  - rst: head=tail=count=0. Outputs next cycle: id_valid=0, id_pc=0, id_inst=NOP_INST, if_ready=1, if_afull=(AFULL_LVL==0), count=0.
  - flush: same state clear as rst. A push or pop in the same cycle is discarded, so the instruction offered during the flush cycle is dropped. Storage array contents need not be cleared.
  - normal push/pop.
- Reset or flush mid-operation: takes effect at the next edge regardless of occupancy. No partial drain.
- count never exceeds DEPTH and never underflows. Pop when empty and push when full are architecturally impossible by construction.
- Simulation-only assertions: DEPTH is a power of two; count <= DEPTH.

Test Plan:
- Reset: assert rst 2 cycles with if_valid=1 -> after release id_valid=0, id_inst=NOP_INST, id_pc=0, count=0, if_ready=1.
- Latency and order: id_ready=0, push pc 0x100/0x104/0x108 (inst 0x00A00093, 0x00100113, 0x002081B3) -> count 3 and if_afull=1 (DEPTH=4); with id_ready=1 they drain in order 0x100, 0x104, 0x108, then bubble.
- Full: push 5 instrs with id_ready=0 -> if_ready=0 after the 4th; 5th is held by IF. With id_ready=1 and if_valid=1 at full, count goes 4->3 and no push occurs. The 5th is accepted the following cycle.
- Simultaneous push/pop plus wrap: steady if_valid=id_ready=1 for 20 cycles at count=2 -> count stays 2; pointers wrap 5 times; output sequence equals input sequence delayed 2 entries.
- Flush: count=3 and flush=1 with if_valid=1 (pc 0x200) -> next cycle count=0 and id_valid=0; pc 0x200 never appears on id_pc. A push of 0x300 the following cycle appears on id_pc one cycle later.
- Reset mid-operation: count=4, assert rst together with id_ready=1 -> next cycle count=0, if_ready=1; no stale entry is ever output afterwards.
